// File: rtl/fir_tap_mac.sv
// fir_tap_mac: sequential multiply-accumulate reader for the 2-D tapped
// shifter. Each start pulse walks tap index 0..tamanyo-1 through the
// shifter's tap select and the coefficient store, one tap per cycle. It
// accumulates signed tap*coef products and emits one signed FIR sample with
// a one-cycle valid strobe.
module fir_tap_mac #(
  parameter int tamanyo = 32,
  parameter int size    = 8,
  localparam int IW     = $clog2(tamanyo),
  localparam int AW     = 2*size + IW
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 start,
  input  logic [size-1:0]      tap_data,
  input  logic [size-1:0]      coef_data,
  output logic [IW-1:0]        seleccion,
  output logic [IW-1:0]        coef_addr,
  output logic                 modo,
  output logic                 busy,
  output logic [AW-1:0]        result,
  output logic                 result_valid
);

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  localparam logic [IW-1:0] LAST = IW'(tamanyo - 1);

  state_t                 state;
  logic [IW-1:0]          idx;
  logic [AW-1:0]          acc;
  logic signed [2*size-1:0] prod;
  logic [AW-1:0]          prod_ext;
  logic [AW-1:0]          acc_next;

  // Signed product of the current tap and coefficient, sign-extended to the
  // accumulator width. The accumulator cannot overflow for tamanyo taps.
  always_comb begin
    prod     = $signed(tap_data) * $signed(coef_data);
    prod_ext = {{IW{prod[2*size-1]}}, prod};
    acc_next = acc + prod_ext;
  end

  // Control and datapath. Clear beats start and beats pass completion.
  // The final product goes straight into result, so no extra drain cycle
  // is needed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      idx          <= '0;
      acc          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else if (!clear) begin
      state        <= IDLE;
      idx          <= '0;
      acc          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          idx <= '0;
          if (start) begin
            state <= ACCUM;
            acc   <= '0;
          end
        end
        ACCUM: begin
          if (idx == LAST) begin
            result       <= acc_next;
            result_valid <= 1'b1;
            acc          <= '0;
            idx          <= '0;
            state        <= IDLE;
          end else begin
            acc <= acc_next;
            idx <= idx + IW'(1);
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  assign busy      = (state == ACCUM);
  assign modo      = busy;
  assign seleccion = idx;
  assign coef_addr = idx;

endmodule

// File: tb/tb_fir_tap_mac.sv
// tb_fir_tap_mac: directed bench for fir_tap_mac. It models the shifter taps
// and the coefficient store as small arrays that are read combinationally.
// Expected sums are hand-computed constants.
module tb_fir_tap_mac;
  localparam int N  = 32;
  localparam int SZ = 8;
  localparam int IW = $clog2(N);
  localparam int AW = 2*SZ + IW;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b1;
  logic          start = 1'b0;
  logic [SZ-1:0] tap_data, coef_data;
  logic [IW-1:0] seleccion, coef_addr;
  logic          modo, busy, result_valid;
  logic [AW-1:0] result;

  logic [SZ-1:0] taps  [N];
  logic [SZ-1:0] coefs [N];

  int n_cmp = 0;
  int n_bad = 0;

  assign tap_data  = taps[seleccion];
  assign coef_data = coefs[coef_addr];

  fir_tap_mac #(.tamanyo(N), .size(SZ)) dut (
    .clock(clock), .reset(reset), .clear(clear), .start(start),
    .tap_data(tap_data), .coef_data(coef_data),
    .seleccion(seleccion), .coef_addr(coef_addr), .modo(modo), .busy(busy),
    .result(result), .result_valid(result_valid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sres();
    return longint'($signed(result));
  endfunction

  task automatic load(input logic [SZ-1:0] t, input logic [SZ-1:0] c, input bit ramp);
    for (int i = 0; i < N; i++) begin
      taps[i]  = ramp ? SZ'(i) : t;
      coefs[i] = c;
    end
  endtask

  // One full pass from a start pulse; checks the index walk, latency and hold.
  task automatic do_pass(input string tag, input longint exp);
    int bad;
    bad = 0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (seleccion != IW'(i) || coef_addr != IW'(i) || !busy || !modo || result_valid)
        bad++;
      @(negedge clock);
    end
    chk({tag, "_walk"}, bad, 0);
    chk({tag, "_valid"}, result_valid, 1);
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_result"}, sres(), exp);
    @(negedge clock);
    chk({tag, "_valid_drop"}, result_valid, 0);
    chk({tag, "_hold"}, sres(), exp);
  endtask

  initial begin
    int vcnt;
    int vcyc [$];
    int bad;

    load(8'd1, 8'd1, 0);
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_result", sres(), 0);
    @(negedge clock);
    reset = 1'b1;

    // idle with start low
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (busy || modo || seleccion != 0 || result != 0 || result_valid) bad++;
    end
    chk("idle", bad, 0);

    do_pass("unit", 32);

    load(8'hFF, 8'h7F, 0);
    do_pass("neg", -4064);
    chk("neg_raw", result, 21'h1FF020);

    load(8'h80, 8'h80, 0);
    do_pass("maxneg", 524288);

    // back-to-back with start held high
    load(8'd0, 8'd1, 1);
    start = 1'b1;
    vcnt = 0;
    bad = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clock);
      if (result_valid) begin
        vcyc.push_back(c);
        if (sres() != 496) bad++;
      end
    end
    start = 1'b0;
    vcnt = vcyc.size();
    chk("b2b_count", vcnt, 3);
    chk("b2b_values", bad, 0);
    if (vcnt == 3) begin
      chk("b2b_first", vcyc[0], 33);
      chk("b2b_gap1", vcyc[1] - vcyc[0], 33);
      chk("b2b_gap2", vcyc[2] - vcyc[1], 33);
    end
    repeat (40) @(negedge clock);

    // abort at idx 10
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    chk("abort_idx", seleccion, 10);
    clear = 1'b0;
    start = 1'b1;
    @(negedge clock);
    clear = 1'b1;
    start = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_sel", seleccion, 0);
    chk("abort_result", sres(), 0);
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (result_valid || busy) vcnt++;
      @(negedge clock);
    end
    chk("abort_quiet", vcnt, 0);
    do_pass("after_abort", 496);

    // async reset mid-pass at idx 20
    load(8'd1, 8'd1, 0);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (20) @(negedge clock);
    chk("ar_idx", seleccion, 20);
    #2 reset = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_modo", modo, 0);
    chk("ar_sel", seleccion, 0);
    chk("ar_result", sres(), 0);
    #4 reset = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (result_valid || busy) vcnt++;
    end
    chk("ar_quiet", vcnt, 0);
    do_pass("after_reset", 32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
